// File: rtl/fetch_pc_if.sv
// Fetch front-end bus: control inputs, the memory PC/instruction pair,
// and the tagged instruction handed to decode.
interface fetch_pc_if #(
  parameter int CNT_W = 16
);
  logic             stall;
  logic             branch_taken;
  logic [31:0]      branch_target;
  logic             jump;
  logic [31:0]      jump_target;
  logic [31:0]      pc;
  logic [31:0]      inst_in;
  logic [31:0]      id_inst;
  logic [31:0]      id_pc4;
  logic             id_valid;
  logic [CNT_W-1:0] fetch_count;

  modport slave (
    input  stall, branch_taken, branch_target,
    input  jump, jump_target, inst_in,
    output pc, id_inst, id_pc4, id_valid, fetch_count
  );

  modport master (
    output stall, branch_taken, branch_target,
    output jump, jump_target, inst_in,
    input  pc, id_inst, id_pc4, id_valid, fetch_count
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// Program counter and fetch/decode alignment stage in front of a
// single-cycle synchronous instruction memory.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          PC_WRAP  = 128,
  parameter int          CNT_W    = 16
) (
  input logic        clock,
  input logic        reset_n,
  fetch_pc_if.slave  bus
);

  // Keeps addresses word-aligned and inside the instruction space.
  localparam logic [31:0] ADDR_MASK =
    32'(PC_WRAP - 1) & 32'hFFFF_FFFC;

  logic [31:0]      r_pc;
  logic [31:0]      r_pc4;
  logic             r_valid;
  logic [CNT_W-1:0] r_cnt;

  logic [31:0] w_seq;
  logic [31:0] w_next;
  logic        w_redir;

  assign w_seq   = (r_pc + 32'd4) & ADDR_MASK;
  assign w_redir = bus.jump | bus.branch_taken;

  always_comb begin
    w_next = w_seq;
    priority case (1'b1)
      bus.jump:         w_next = bus.jump_target & ADDR_MASK;
      bus.branch_taken: w_next = bus.branch_target & ADDR_MASK;
      bus.stall:        w_next = r_pc;
      default:          w_next = w_seq;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pc    <= RESET_PC & ADDR_MASK;
      r_pc4   <= '0;
      r_valid <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_pc    <= w_next;
      r_pc4   <= w_seq;
      r_valid <= ~w_redir;
      if (!w_redir && !bus.stall)
        r_cnt <= r_cnt + 1'b1;
    end
  end

  assign bus.pc          = r_pc;
  assign bus.id_pc4      = r_pc4;
  assign bus.id_valid    = r_valid;
  assign bus.id_inst     = r_valid ? bus.inst_in : 32'h0;
  assign bus.fetch_count = r_cnt;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed scoreboard bench for fetch_pc_unit with a behavioural
// 32-word synchronous instruction memory.
module tb_fetch_pc_unit;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] pc4;
    logic        v;
    logic [15:0] cnt;
  } exp_t;

  logic clock;
  logic reset_n;
  logic [31:0] mem [32];

  exp_t q[$];
  exp_t e;
  int n_cmp;
  int n_bad;

  fetch_pc_if #(.CNT_W(16)) bus ();

  fetch_pc_unit #(
    .RESET_PC(32'h0),
    .PC_WRAP(128),
    .CNT_W(16)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .bus(bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock)
    bus.inst_in <= mem[bus.pc[6:2]];

  always @(negedge clock) begin
    while (q.size() > 0) begin
      e = q.pop_front();
      n_cmp++;
      if (bus.pc !== e.pc || bus.id_inst !== e.inst ||
          bus.id_pc4 !== e.pc4 || bus.id_valid !== e.v ||
          bus.fetch_count !== e.cnt) begin
        n_bad++;
        $display("FAIL %s: got pc=%h inst=%h pc4=%h v=%b cnt=%0d exp pc=%h inst=%h pc4=%h v=%b cnt=%0d",
          e.name, bus.pc, bus.id_inst, bus.id_pc4, bus.id_valid,
          bus.fetch_count, e.pc, e.inst, e.pc4, e.v, e.cnt);
      end
    end
  end

  function automatic exp_t mk(string n, logic [31:0] pc,
    logic [31:0] inst, logic [31:0] pc4, logic v, logic [15:0] cnt);
    exp_t x;
    x.name = n; x.pc = pc; x.inst = inst;
    x.pc4 = pc4; x.v = v; x.cnt = cnt;
    return x;
  endfunction

  task automatic step(input logic j, input logic b, input logic s,
    input logic [31:0] jt, input logic [31:0] bt, input exp_t x);
    bus.jump = j; bus.branch_taken = b; bus.stall = s;
    bus.jump_target = jt; bus.branch_target = bt;
    @(posedge clock);
    #1;
    q.push_back(x);
  endtask

  task automatic seq(input exp_t x);
    step(0, 0, 0, 32'h0, 32'h0, x);
  endtask

  // Reset lands between edges; the check precedes any further posedge.
  task automatic do_reset(input string n);
    bus.jump = 0; bus.branch_taken = 0; bus.stall = 0;
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1 q.push_back(mk(n, 32'h0, 32'h0, 32'h0, 1'b0, 16'd0));
    @(negedge clock);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0; n_bad = 0;
    for (int i = 0; i < 32; i++) mem[i] = 32'hA000_0000 + 32'(i * 4);
    mem[0] = 32'h2008_0001;
    mem[1] = 32'h2009_0002;
    mem[2] = 32'h200A_0003;
    mem[3] = 32'h8C11_0008;
    mem[4] = 32'h8C12_0004;
    mem[5] = 32'h0232_4020;
    reset_n = 1'b0;
    bus.stall = 0; bus.jump = 0; bus.branch_taken = 0;
    bus.jump_target = 0; bus.branch_target = 0;

    // sequential run
    do_reset("rst0");
    seq(mk("t1e1", 32'd4,  32'h2008_0001, 32'd4,  1, 16'd1));
    seq(mk("t1e2", 32'd8,  32'h2009_0002, 32'd8,  1, 16'd2));
    seq(mk("t1e3", 32'd12, 32'h200A_0003, 32'd12, 1, 16'd3));
    seq(mk("t1e4", 32'd16, 32'h8C11_0008, 32'd16, 1, 16'd4));
    seq(mk("t1e5", 32'd20, 32'h8C12_0004, 32'd20, 1, 16'd5));
    seq(mk("t1e6", 32'd24, 32'h0232_4020, 32'd24, 1, 16'd6));

    // stall at pc=16
    do_reset("rst1");
    seq(mk("t2a", 32'd4,  32'h2008_0001, 32'd4,  1, 16'd1));
    seq(mk("t2b", 32'd8,  32'h2009_0002, 32'd8,  1, 16'd2));
    seq(mk("t2c", 32'd12, 32'h200A_0003, 32'd12, 1, 16'd3));
    seq(mk("t2d", 32'd16, 32'h8C11_0008, 32'd16, 1, 16'd4));
    for (int k = 0; k < 3; k++)
      step(0, 0, 1, 0, 0,
        mk("t2stall", 32'd16, 32'h8C12_0004, 32'd20, 1, 16'd4));

    // branch with misaligned target, then jump+branch+stall
    do_reset("rst2");
    seq(mk("t3a", 32'd4, 32'h2008_0001, 32'd4, 1, 16'd1));
    seq(mk("t3b", 32'd8, 32'h2009_0002, 32'd8, 1, 16'd2));
    step(0, 1, 0, 0, 32'h0000_0016,
      mk("t3br", 32'd20, 32'h0, 32'd12, 0, 16'd2));
    seq(mk("t3nx", 32'd24, 32'h0232_4020, 32'd24, 1, 16'd3));
    step(1, 1, 1, 32'h0, 32'd40,
      mk("t4jb", 32'd0, 32'h0, 32'd28, 0, 16'd3));
    seq(mk("t4nx", 32'd4, 32'h2008_0001, 32'd4, 1, 16'd4));
    step(1, 0, 0, 32'h0000_0087, 0,
      mk("jmis", 32'd4, 32'h0, 32'd8, 0, 16'd4));
    seq(mk("jmnx", 32'd8, 32'h2009_0002, 32'd8, 1, 16'd5));

    // wrap-around at the top of the instruction space
    step(1, 0, 0, 32'd120, 0,
      mk("t5j", 32'd120, 32'h0, 32'd12, 0, 16'd5));
    seq(mk("t5a", 32'd124, 32'hA000_0078, 32'd124, 1, 16'd6));
    seq(mk("t5w", 32'd0,   32'hA000_007C, 32'd0,   1, 16'd7));
    seq(mk("t5z", 32'd4,   32'h2008_0001, 32'd4,   1, 16'd8));
    step(0, 1, 1, 0, 32'd12,
      mk("brst", 32'd12, 32'h0, 32'd8, 0, 16'd8));

    // asynchronous reset mid-run
    do_reset("rst3");
    seq(mk("t6a", 32'd4,  32'h2008_0001, 32'd4,  1, 16'd1));
    seq(mk("t6b", 32'd8,  32'h2009_0002, 32'd8,  1, 16'd2));
    seq(mk("t6c", 32'd12, 32'h200A_0003, 32'd12, 1, 16'd3));
    seq(mk("t6d", 32'd16, 32'h8C11_0008, 32'd16, 1, 16'd4));
    seq(mk("t6e", 32'd20, 32'h8C12_0004, 32'd20, 1, 16'd5));
    do_reset("t6rst");
    seq(mk("t6rel", 32'd4, 32'h2008_0001, 32'd4, 1, 16'd1));

    @(negedge clock);
    #1;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending exp 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
      n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
Instruction-fetch front end that sits directly upstream of the 32-word synchronous instruction memory. It owns the program counter and drives the memory's PC input. It selects the next PC from sequential, branch and jump sources, handles stalls and redirects, and tags the instruction the memory returns one cycle later with its PC+4 and a valid bit for the decode stage. Redirected (wrong-path) fetches are squashed to NOP.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
PC_WRAP, 128, byte size of the instruction space (32 words × 4); power of two; all PC arithmetic is modulo PC_WRAP.
CNT_W, 16, width of the retired-fetch counter.

Ports:
clock  input  1  system clock; all state updates on posedge.
reset_n  input  1  asynchronous, active-low reset.
stall  input  1  hold PC; current fetch is not advanced.
branch_taken  input  1  redirect to branch_target at next edge.
branch_target  input  32  branch destination byte address.
jump  input  1  redirect to jump_target at next edge.
jump_target  input  32  jump destination byte address.
pc  output  32  current PC; connects to the instruction memory PC input.
inst_in  input  32  instruction from memory, registered one edge after pc.
id_inst  output  32  instruction to decode; 32'h0 (NOP) when id_valid=0.
id_pc4  output  32  PC+4 of the instruction on id_inst.
id_valid  output  1  id_inst is a real, on-path instruction.
fetch_count  output  CNT_W  number of valid instructions delivered since reset.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - pc = RESET_PC; id_pc4 register = 0; valid register = 0; fetch_count = 0.
  - Outputs are valid immediately, without a clock edge.
- Memory timing: at each posedge the memory captures mem[pc/4] while this block updates pc. After edge k, inst_in holds mem[pc_k].
- Alignment register: at each edge, capture pc4_q = (pc_k + 4) mod PC_WRAP and valid_q per the rules below. Then id_pc4 = pc4_q, id_valid = valid_q, and id_inst = valid_q ? inst_in : 32'h0.
- Next-PC priority (highest first):
  - jump: pc <= jump_target & ~3, mod PC_WRAP.
  - branch_taken: pc <= branch_target & ~3, mod PC_WRAP.
  - stall: pc holds.
  - Otherwise: pc <= (pc + 4) mod PC_WRAP.
- Valid rules at each edge:
  - valid_q <= 0 if jump or branch_taken. The word fetched at this edge is wrong-path and is squashed.
  - Otherwise valid_q <= 1, including during a stall. The memory re-reads the held pc, so the same instruction is re-presented. Decode owns stall semantics.
- Simultaneous events:
  - jump and branch_taken together: jump wins.
  - Redirect together with stall: the redirect wins and the stall is ignored for pc.
- Misaligned targets: the low 2 bits are silently cleared; no error flag.
- Wrap-around: pc = PC_WRAP−4 sequentially goes to 0. id_pc4 for that word is 0.
- fetch_count: increments by 1 on each edge where valid_q is 1 and stall is 0. It wraps modulo 2^CNT_W.
- Reset asserted mid-operation: all state clears at once. The first edge after release fetches RESET_PC with valid_q = 1.
- No combinational path from any input to pc. pc is purely registered.

Test Plan:
1. Reset, then release and run 6 edges with no controls: pc goes 0,4,8,12,16,20,24; id_pc4 lags one edge. After edge 4, id_inst = 32'h8C110008 and id_pc4 = 16. fetch_count = 6.
2. Stall held for 3 edges while pc = 16: pc stays 16. id_inst repeats 32'h8C120004 with id_valid = 1, and fetch_count does not advance.
3. At pc = 8, branch_taken = 1 with branch_target = 32'h0000_0016: pc becomes 20 (aligned). The next edge gives id_valid = 0 and id_inst = 0. The following edge gives id_inst = 32'h0232_4020 and id_pc4 = 24.
4. jump = 1 (target 0) and branch_taken = 1 (target 40) on the same edge while stall = 1: pc becomes 0 and the squash is applied.
5. Sequential run to pc = 124 then one more edge: pc = 0, and id_pc4 for the word fetched at 124 reads 0.
6. Assert reset_n = 0 between edges with pc = 20 and fetch_count = 5: pc, id_valid and fetch_count go to 0 immediately, with no clock edge.
